// File: rtl/latency_meter_if.sv
// Stimulus/echo inputs and measurement results of latency_meter.
interface latency_meter_if #(
  parameter int unsigned LSIZE = 10
);
  logic             en;
  logic             d;
  logic             q;
  logic [LSIZE-1:0] lat_rise;
  logic             rise_vld;
  logic [LSIZE-1:0] lat_fall;
  logic             fall_vld;
  logic             timeout;
  logic             overrun;
  logic             busy;

  modport master (
    output en, d, q,
    input  lat_rise, rise_vld, lat_fall, fall_vld, timeout, overrun, busy
  );

  modport slave (
    input  en, d, q,
    output lat_rise, rise_vld, lat_fall, fall_vld, timeout, overrun, busy
  );
endinterface

// File: rtl/latency_meter.sv
// Measures edge-to-edge delay (in cycles) from stimulus d to its echo q,
// with independent rise and fall channels, timeout and overrun flags.
module latency_meter #(
  parameter int unsigned LSIZE   = 10,
  parameter int unsigned MAX_LAT = 1000
) (
  input  logic            clock,
  input  logic            rst_n,
  latency_meter_if.slave  bus
);

  localparam int unsigned NCH = 2;  // channel 0 = rise, channel 1 = fall
  localparam logic [LSIZE-1:0] MAX_CNT = LSIZE'(MAX_LAT);

  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_e;

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [LSIZE-1:0] cnt_q   [NCH];
  logic [LSIZE-1:0] cnt_d   [NCH];
  logic [LSIZE-1:0] lat_q   [NCH];
  logic [LSIZE-1:0] lat_d   [NCH];
  logic [NCH-1:0]   vld_q, vld_d;
  logic [NCH-1:0]   to_d, ov_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             d_prev_q, d_prev_d;
  logic             q_prev_q, q_prev_d;
  logic [NCH-1:0]   d_edge_c, q_edge_c;

  // Edge detection and per-channel next-state / result computation.
  always_comb begin
    d_prev_d    = bus.d;
    q_prev_d    = bus.q;
    d_edge_c[0] = bus.d & ~d_prev_q;
    d_edge_c[1] = ~bus.d & d_prev_q;
    q_edge_c[0] = bus.q & ~q_prev_q;
    q_edge_c[1] = ~bus.q & q_prev_q;
    vld_d       = '0;
    to_d        = '0;
    ov_d        = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      lat_d[ch]   = lat_q[ch];
      case (state_q[ch])
        IDLE: begin
          if (d_edge_c[ch] && bus.en) begin
            if (q_edge_c[ch]) begin
              lat_d[ch] = '0;
              vld_d[ch] = 1'b1;
            end else begin
              state_d[ch] = MEAS;
              cnt_d[ch]   = LSIZE'(1);
            end
          end
        end
        MEAS: begin
          ov_d[ch] = d_edge_c[ch];
          if (q_edge_c[ch]) begin
            lat_d[ch]   = cnt_q[ch];
            vld_d[ch]   = 1'b1;
            state_d[ch] = IDLE;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == MAX_CNT) begin
            to_d[ch]    = 1'b1;
            state_d[ch] = IDLE;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + LSIZE'(1);
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
    timeout_d = |to_d;
    overrun_d = |ov_d;
    busy_d    = (state_d[0] == MEAS) || (state_d[1] == MEAS);
  end

  // State, counters, edge history and registered outputs; synchronous reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
        lat_q[ch]   <= '0;
      end
      vld_q     <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      d_prev_q  <= 1'b0;
      q_prev_q  <= 1'b0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        lat_q[ch]   <= lat_d[ch];
      end
      vld_q     <= vld_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      d_prev_q  <= d_prev_d;
      q_prev_q  <= q_prev_d;
    end
  end

  // Drive the result interface from the registered state.
  assign bus.lat_rise = lat_q[0];
  assign bus.rise_vld = vld_q[0];
  assign bus.lat_fall = lat_q[1];
  assign bus.fall_vld = vld_q[1];
  assign bus.timeout  = timeout_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_latency_meter.sv
// Directed bench for latency_meter: cycle-index reference model plus
// hand-computed per-scenario expectations.
module tb_latency_meter;

  localparam int unsigned LSIZE   = 10;
  localparam int unsigned MAX_LAT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        q_low;
  int          dly;
  logic [15:0] dl = '0;

  latency_meter_if #(.LSIZE(LSIZE)) bus ();

  latency_meter #(.LSIZE(LSIZE), .MAX_LAT(MAX_LAT)) dut (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // External delay line: q is d registered dly times (or forced low).
  always @(posedge clk) dl <= {dl[14:0], bus.d};
  always_comb begin
    if (q_low)         bus.q = 1'b0;
    else if (dly == 0) bus.q = bus.d;
    else               bus.q = dl[dly-1];
  end

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: remembers the cycle index of each pending d edge.
  logic       m_dp, m_qp;
  logic       m_act   [2];
  int         m_start [2];
  int         e_lat   [2];
  logic       e_vld   [2];
  logic       e_to, e_ov, e_busy;

  always @(posedge clk) begin
    logic de [2];
    logic qe [2];
    cyc++;
    if (!rst_n) begin
      m_dp = 1'b0; m_qp = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_act[c] = 1'b0; e_lat[c] = 0; e_vld[c] = 1'b0;
      end
      e_to = 1'b0; e_ov = 1'b0; e_busy = 1'b0;
    end else begin
      de[0] = bus.d && !m_dp;  de[1] = !bus.d && m_dp;
      qe[0] = bus.q && !m_qp;  qe[1] = !bus.q && m_qp;
      e_to = 1'b0; e_ov = 1'b0;
      for (int c = 0; c < 2; c++) begin
        e_vld[c] = 1'b0;
        if (m_act[c]) begin
          if (de[c]) e_ov = 1'b1;
          if (qe[c]) begin
            e_lat[c] = cyc - m_start[c]; e_vld[c] = 1'b1; m_act[c] = 1'b0;
          end else if (cyc - m_start[c] == MAX_LAT) begin
            e_to = 1'b1; m_act[c] = 1'b0;
          end
        end else if (de[c] && bus.en) begin
          if (qe[c]) begin
            e_lat[c] = 0; e_vld[c] = 1'b1;
          end else begin
            m_act[c] = 1'b1; m_start[c] = cyc;
          end
        end
      end
      m_dp = bus.d; m_qp = bus.q;
      e_busy = m_act[0] || m_act[1];
    end
  end

  // Per-scenario observations of DUT pulses.
  int rise_cnt, fall_cnt, to_cnt, ov_cnt, busy_cnt, to_cyc;

  task automatic clear_obs();
    rise_cnt = 0; fall_cnt = 0; to_cnt = 0; ov_cnt = 0; busy_cnt = 0; to_cyc = -1;
  endtask

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      cmp("lat_rise", 32'(bus.lat_rise), 32'(e_lat[0]));
      cmp("rise_vld", 32'(bus.rise_vld), 32'(e_vld[0]));
      cmp("lat_fall", 32'(bus.lat_fall), 32'(e_lat[1]));
      cmp("fall_vld", 32'(bus.fall_vld), 32'(e_vld[1]));
      cmp("timeout",  32'(bus.timeout),  32'(e_to));
      cmp("overrun",  32'(bus.overrun),  32'(e_ov));
      cmp("busy",     32'(bus.busy),     32'(e_busy));
      if (bus.rise_vld === 1'b1) rise_cnt++;
      if (bus.fall_vld === 1'b1) fall_cnt++;
      if (bus.overrun  === 1'b1) ov_cnt++;
      if (bus.busy     === 1'b1) busy_cnt++;
      if (bus.timeout  === 1'b1) begin to_cnt++; to_cyc = cyc; end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    rst_n = 1'b0; bus.en = 1'b0; bus.d = 1'b0; q_low = 1'b0; dly = 0;
    clear_obs();
    step(3);
    cmp("reset lat_rise", 32'(bus.lat_rise), 0);
    cmp("reset busy",     32'(bus.busy),     0);
    rst_n = 1'b1; bus.en = 1'b1;

    // Delay 5, 20-cycle pulse.
    dly = 5; step(2); clear_obs();
    bus.d = 1'b1; step(20); bus.d = 1'b0; step(15);
    cmp("d5 rise count", 32'(rise_cnt), 1);
    cmp("d5 lat_rise",   32'(bus.lat_rise), 5);
    cmp("d5 fall count", 32'(fall_cnt), 1);
    cmp("d5 lat_fall",   32'(bus.lat_fall), 5);
    cmp("d5 timeouts",   32'(to_cnt), 0);
    cmp("d5 overruns",   32'(ov_cnt), 0);
    cmp("d5 busy cycles",32'(busy_cnt), 10);

    // Timeout with q held low, then normal measurement at delay 4.
    q_low = 1'b1; clear_obs();
    bus.d = 1'b1; t0 = cyc; step(25);
    cmp("to count",     32'(to_cnt), 1);
    cmp("to latency",   32'(to_cyc - t0), 17);
    cmp("to rise count",32'(rise_cnt), 0);
    cmp("to lat_rise",  32'(bus.lat_rise), 5);
    dly = 4; q_low = 1'b0; step(2); clear_obs();
    bus.d = 1'b0; step(8); bus.d = 1'b1; step(8);
    cmp("post-to fall count", 32'(fall_cnt), 1);
    cmp("post-to lat_fall",   32'(bus.lat_fall), 4);
    cmp("post-to rise count", 32'(rise_cnt), 1);
    cmp("post-to lat_rise",   32'(bus.lat_rise), 4);
    cmp("post-to timeouts",   32'(to_cnt), 0);
    bus.d = 1'b0; step(8);

    // Zero delay: q follows d in the same cycle.
    dly = 0; step(2); clear_obs();
    repeat (3) begin bus.d = 1'b1; step(4); bus.d = 1'b0; step(4); end
    cmp("zero rise count", 32'(rise_cnt), 3);
    cmp("zero fall count", 32'(fall_cnt), 3);
    cmp("zero lat_rise",   32'(bus.lat_rise), 0);
    cmp("zero busy cycles",32'(busy_cnt), 0);

    // Overrun: second rise 3 cycles after the first at delay 8.
    dly = 8; step(10); clear_obs();
    bus.d = 1'b1; step(1); bus.d = 1'b0; step(2); bus.d = 1'b1; step(12);
    bus.d = 1'b0; step(15);
    cmp("ovr rise count", 32'(rise_cnt), 1);
    cmp("ovr lat_rise",   32'(bus.lat_rise), 8);
    cmp("ovr overruns",   32'(ov_cnt), 1);
    cmp("ovr fall count", 32'(fall_cnt), 2);
    cmp("ovr lat_fall",   32'(bus.lat_fall), 8);
    cmp("ovr timeouts",   32'(to_cnt), 0);

    // Enable gating.
    bus.en = 1'b0; dly = 3; clear_obs();
    repeat (2) begin bus.d = 1'b1; step(5); bus.d = 1'b0; step(5); end
    cmp("en0 rise count", 32'(rise_cnt), 0);
    cmp("en0 fall count", 32'(fall_cnt), 0);
    cmp("en0 busy cycles",32'(busy_cnt), 0);
    clear_obs();
    bus.d = 1'b1; step(2); bus.en = 1'b1; step(4); bus.d = 1'b0; step(8);
    cmp("en1 rise count", 32'(rise_cnt), 0);
    cmp("en1 fall count", 32'(fall_cnt), 1);
    cmp("en1 lat_fall",   32'(bus.lat_fall), 3);

    // Reset in the middle of a delay-10 measurement.
    dly = 10; step(12); clear_obs();
    bus.d = 1'b1; step(3);
    rst_n = 1'b0; bus.d = 1'b0; step(1);
    cmp("rst lat_rise", 32'(bus.lat_rise), 0);
    cmp("rst lat_fall", 32'(bus.lat_fall), 0);
    cmp("rst busy",     32'(bus.busy),     0);
    step(1); rst_n = 1'b1; step(15);
    cmp("rst rise count", 32'(rise_cnt), 0);
    cmp("rst fall count", 32'(fall_cnt), 0);
    clear_obs();
    bus.d = 1'b1; step(14); bus.d = 1'b0; step(14);
    cmp("post-rst rise count", 32'(rise_cnt), 1);
    cmp("post-rst lat_rise",   32'(bus.lat_rise), 10);
    cmp("post-rst fall count", 32'(fall_cnt), 1);
    cmp("post-rst lat_fall",   32'(bus.lat_fall), 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
